// File: rtl/mem_ctrl_arbiter.sv
// Shares the single memory bus between dcache and icache and routes load returns to the tag owner.
// Build option: define MEM_ARB_FAIR_EN to force an icache grant after STARVE_LIMIT lost arbitrations.
module mem_ctrl_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic [1:0]      dcache2ctlr_command,
    input  logic [XLEN-1:0] dcache2ctlr_addr,
    input  logic [63:0]     dcache2ctlr_data,
    output logic [3:0]      Ctlr2dcache_response,
    output logic [63:0]     Ctlr2dcache_data,
    output logic [3:0]      Ctlr2dcache_tag,

    input  logic [1:0]      icache2ctlr_command,
    input  logic [XLEN-1:0] icache2ctlr_addr,
    output logic [3:0]      Ctlr2icache_response,
    output logic [63:0]     Ctlr2icache_data,
    output logic [3:0]      Ctlr2icache_tag,

    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag
);

    localparam int unsigned NUM_TAGS = 16;
    localparam int unsigned CNT_W    = 4;
    localparam logic [1:0]  BUS_NONE = 2'd0;
    localparam logic [1:0]  BUS_LOAD = 2'd1;

    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_starve_limit_check
        $error("mem_ctrl_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic dcache_req_c;
    logic icache_req_c;
    logic force_icache_c;
    logic icache_win_c;
    logic dcache_win_c;
    logic [1:0] winner_cmd_c;
    logic alloc_c;
    logic ret_hit_c;
    logic ret_owner_c;

    // Per-tag ownership: valid bit plus owner (0 = dcache, 1 = icache); tag 0 never valid.
    logic [NUM_TAGS-1:0] valid_q;
    logic [NUM_TAGS-1:0] valid_d;
    logic [NUM_TAGS-1:0] owner_q;
    logic [NUM_TAGS-1:0] owner_d;

    always_comb begin
        dcache_req_c = (dcache2ctlr_command != BUS_NONE);
        icache_req_c = (icache2ctlr_command != BUS_NONE);
    end

`ifdef MEM_ARB_FAIR_EN
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    always_comb begin
        force_icache_c = icache_req_c && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    end

    // Counts consecutive icache losses, saturating at the limit.
    always_comb begin
        starve_cnt_d = '0;
        if (icache_req_c && !icache_win_c) begin
            if (starve_cnt_q == CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    always_comb begin
        force_icache_c = 1'b0;
    end
`endif

    always_comb begin
        icache_win_c = icache_req_c && (!dcache_req_c || force_icache_c);
        dcache_win_c = dcache_req_c && !icache_win_c;
        winner_cmd_c = BUS_NONE;
        if (dcache_win_c) begin
            winner_cmd_c = dcache2ctlr_command;
        end else if (icache_win_c) begin
            winner_cmd_c = icache2ctlr_command;
        end
        alloc_c     = (mem2proc_response != '0) && (winner_cmd_c == BUS_LOAD);
        ret_hit_c   = (mem2proc_tag != '0) && valid_q[mem2proc_tag];
        ret_owner_c = owner_q[mem2proc_tag];
    end

    // Clear on return first so a same-cycle re-accept of that tag wins.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (ret_hit_c) begin
            valid_d[mem2proc_tag] = 1'b0;
        end
        if (alloc_c) begin
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = icache_win_c;
        end
        valid_d[0] = 1'b0;
        owner_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    // Forward path, accept steering and return routing; everything held at 0 in reset.
    always_comb begin
        proc2mem_command     = BUS_NONE;
        proc2mem_addr        = '0;
        proc2mem_data        = '0;
        Ctlr2dcache_response = '0;
        Ctlr2dcache_data     = '0;
        Ctlr2dcache_tag      = '0;
        Ctlr2icache_response = '0;
        Ctlr2icache_data     = '0;
        Ctlr2icache_tag      = '0;
        if (!reset) begin
            if (dcache_win_c) begin
                proc2mem_command     = dcache2ctlr_command;
                proc2mem_addr        = dcache2ctlr_addr;
                proc2mem_data        = dcache2ctlr_data;
                Ctlr2dcache_response = mem2proc_response;
            end else if (icache_win_c) begin
                proc2mem_command     = icache2ctlr_command;
                proc2mem_addr        = icache2ctlr_addr;
                Ctlr2icache_response = mem2proc_response;
            end
            if (ret_hit_c) begin
                if (ret_owner_c) begin
                    Ctlr2icache_data = mem2proc_data;
                    Ctlr2icache_tag  = mem2proc_tag;
                end else begin
                    Ctlr2dcache_data = mem2proc_data;
                    Ctlr2dcache_tag  = mem2proc_tag;
                end
            end
        end
    end

endmodule
